// File: rtl/roll_pkg.sv
// Shared types and defaults for the rollover generator.
// Holds the FSM state type and default widths.
package roll_pkg;

  localparam int DEF_WIDTH     = 16;
  localparam int DEF_CNT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } roll_state_t;

endpackage

// File: rtl/roll_over_gen_limit_shadow.sv
// limit_shadow: pending-limit register behind a valid/ready handshake.
// Ports: i_capture (store transfers), i_wrap, o_xfer, o_pend_limit, o_apply.
module limit_shadow
  import roll_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_capture,
  input  logic             i_limit_valid,
  input  logic [WIDTH-1:0] i_limit,
  input  logic             i_wrap,
  output logic             o_limit_ready,
  output logic             o_xfer,
  output logic [WIDTH-1:0] o_pend_limit,
  output logic             o_apply
);

  logic             ready_q;
  logic [WIDTH-1:0] pend_q;

  assign o_limit_ready = ready_q;
  assign o_pend_limit  = pend_q;
  assign o_xfer        = i_limit_valid & ready_q;
  // Pending holds a limit exactly when ready is low.
  assign o_apply       = i_wrap & ~ready_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ready_q <= 1'b1;
      pend_q  <= '0;
    end else if (o_apply) begin
      ready_q <= 1'b1;
    end else if (o_xfer && i_capture) begin
      pend_q  <= i_limit;
      ready_q <= 1'b0;
    end
  end

endmodule

// File: rtl/roll_over_gen.sv
// roll_over_gen: programmable-period counter with rollover pulse.
// Ports: limit handshake in, o_count/o_roll_over/o_roll_cnt/o_running out.
module roll_over_gen
  import roll_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic [WIDTH-1:0]     i_limit,
  input  logic                 i_limit_valid,
  output logic                 o_limit_ready,
  output logic                 o_roll_over,
  output logic [WIDTH-1:0]     o_count,
  output logic [CNT_WIDTH-1:0] o_roll_cnt,
  output logic                 o_running
);

  roll_state_t          state;
  logic [WIDTH-1:0]     count;
  logic [WIDTH-1:0]     act_limit;
  logic [CNT_WIDTH-1:0] roll_cnt;
  logic                 roll_q;
  logic                 run_q;

  logic             advance;
  logic             wrap;
  logic             xfer;
  logic             apply;
  logic [WIDTH-1:0] pend_limit;

  assign advance = (state == S_RUN) & i_enable;
  assign wrap    = advance & (count == act_limit);

  limit_shadow #(
    .WIDTH(WIDTH)
  ) u_shadow (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_capture    (state != S_IDLE),
    .i_limit_valid(i_limit_valid),
    .i_limit      (i_limit),
    .i_wrap       (wrap),
    .o_limit_ready(o_limit_ready),
    .o_xfer       (xfer),
    .o_pend_limit (pend_limit),
    .o_apply      (apply)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= S_IDLE;
      count     <= '0;
      act_limit <= '0;
      roll_cnt  <= '0;
      roll_q    <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      roll_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (xfer) begin
            act_limit <= i_limit;
            count     <= '0;
            state     <= i_enable ? S_RUN : S_HOLD;
            run_q     <= i_enable;
          end
        end
        S_RUN, S_HOLD: begin
          state <= i_enable ? S_RUN : S_HOLD;
          run_q <= i_enable;
          if (wrap) begin
            count    <= '0;
            roll_q   <= 1'b1;
            roll_cnt <= roll_cnt + CNT_WIDTH'(1);
            if (apply) act_limit <= pend_limit;
          end else if (advance) begin
            count <= count + WIDTH'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          run_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_count     = count;
  assign o_roll_over = roll_q;
  assign o_roll_cnt  = roll_cnt;
  assign o_running   = run_q;

endmodule

// File: tb/tb_roll_over_gen.sv
// Testbench for roll_over_gen: vector table, corner sequences, random vs model.
// Prints one summary line.
module tb_roll_over_gen;

  localparam int W  = 16;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic          val = 1'b0;
  logic [W-1:0]  lim = '0;
  logic          rdy;
  logic          ro;
  logic [W-1:0]  cnt;
  logic [CW-1:0] rc;
  logic          run;

  roll_over_gen #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_enable     (en),
    .i_limit      (lim),
    .i_limit_valid(val),
    .o_limit_ready(rdy),
    .o_roll_over  (ro),
    .o_count      (cnt),
    .o_roll_cnt   (rc),
    .o_running    (run)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference: active limit (-1 = none), pending queue, period position.
  int m_act = -1;
  int m_pend[$];
  int m_cnt = 0;
  int m_rc  = 0;
  bit m_ro  = 0;
  bit m_run = 0;

  task automatic chk(string nm, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_edge(bit r, bit e, bit v, int l);
    bit acc;
    acc = v && (m_pend.size() == 0);
    if (r) begin
      m_act = -1;
      m_pend.delete();
      m_cnt = 0;
      m_rc  = 0;
      m_ro  = 0;
      m_run = 0;
    end else if (m_act < 0) begin
      m_ro = 0;
      if (acc) begin
        m_act = l;
        m_cnt = 0;
        m_run = e;
      end
    end else begin
      m_ro = 0;
      if (m_run && e) begin
        if (m_cnt == m_act) begin
          m_cnt = 0;
          m_ro  = 1;
          m_rc  = (m_rc + 1) % (1 << CW);
          if (m_pend.size() > 0) m_act = m_pend.pop_front();
        end else begin
          m_cnt++;
        end
      end
      if (acc) m_pend.push_back(l);
      m_run = e;
    end
  endtask

  task automatic step(bit r, bit e, bit v, int l);
    rst = r;
    en  = e;
    val = v;
    lim = l[W-1:0];
    @(posedge clk);
    model_edge(r, e, v, l);
    #1;
    chk("model.count", int'(cnt), m_cnt);
    chk("model.roll_over", int'(ro), int'(m_ro));
    chk("model.roll_cnt", int'(rc), m_rc);
    chk("model.running", int'(run), int'(m_run));
    chk("model.ready", int'(rdy), int'(m_pend.size() == 0));
  endtask

  typedef struct {
    bit rst; bit en; bit val; int lim;
    int cnt; bit ro; int rc; bit run; bit rdy;
  } vec_t;

  vec_t tbl[$];
  int   e34[7];

  initial begin
    // rst en val lim | cnt ro rc run rdy
    tbl.push_back('{1,0,0,0, 0,0,0,0,1});
    tbl.push_back('{0,1,1,3, 0,0,0,1,1});
    tbl.push_back('{0,1,0,0, 1,0,0,1,1});
    tbl.push_back('{0,1,0,0, 2,0,0,1,1});
    tbl.push_back('{0,1,0,0, 3,0,0,1,1});
    tbl.push_back('{0,1,0,0, 0,1,1,1,1});
    tbl.push_back('{0,1,0,0, 1,0,1,1,1});
    tbl.push_back('{0,1,0,0, 2,0,1,1,1});
    tbl.push_back('{0,1,0,0, 3,0,1,1,1});
    tbl.push_back('{0,1,0,0, 0,1,2,1,1});
    tbl.push_back('{0,1,0,0, 1,0,2,1,1});
    tbl.push_back('{0,1,0,0, 2,0,2,1,1});
    tbl.push_back('{0,1,0,0, 3,0,2,1,1});
    tbl.push_back('{0,1,1,1, 0,1,3,1,0});
    tbl.push_back('{0,1,0,0, 1,0,3,1,0});
    tbl.push_back('{0,1,0,0, 2,0,3,1,0});
    tbl.push_back('{0,1,0,0, 3,0,3,1,0});
    tbl.push_back('{0,1,0,0, 0,1,4,1,1});
    tbl.push_back('{0,1,0,0, 1,0,4,1,1});
    tbl.push_back('{0,1,0,0, 0,1,5,1,1});
    tbl.push_back('{0,1,0,0, 1,0,5,1,1});
    tbl.push_back('{0,1,0,0, 0,1,6,1,1});
    tbl.push_back('{0,0,0,0, 0,0,6,0,1});
    tbl.push_back('{0,0,1,4, 0,0,6,0,0});
    tbl.push_back('{0,1,0,0, 0,0,6,1,0});
    tbl.push_back('{0,1,0,0, 1,0,6,1,0});
    tbl.push_back('{0,1,0,0, 0,1,7,1,1});
    tbl.push_back('{0,1,0,0, 1,0,7,1,1});

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].en, tbl[i].val, tbl[i].lim);
      chk($sformatf("vec%0d.count", i), int'(cnt), tbl[i].cnt);
      chk($sformatf("vec%0d.roll_over", i), int'(ro), int'(tbl[i].ro));
      chk($sformatf("vec%0d.roll_cnt", i), int'(rc), tbl[i].rc);
      chk($sformatf("vec%0d.running", i), int'(run), int'(tbl[i].run));
      chk($sformatf("vec%0d.ready", i), int'(rdy), int'(tbl[i].rdy));
    end

    // Limit 0: pulse every cycle, roll count wraps 255 -> 0.
    step(1, 0, 0, 0);
    step(0, 1, 1, 0);
    chk("lim0.first_ro", int'(ro), 0);
    repeat (255) step(0, 1, 0, 0);
    chk("lim0.rc255", int'(rc), 255);
    chk("lim0.ro", int'(ro), 1);
    chk("lim0.count", int'(cnt), 0);
    step(0, 1, 0, 0);
    chk("lim0.rc_wrap", int'(rc), 0);
    chk("lim0.ro_wrap", int'(ro), 1);

    // Limit 5 running, new limit 2 at count 1.
    step(1, 0, 0, 0);
    step(0, 1, 1, 5);
    step(0, 1, 0, 0);
    chk("chg.count1", int'(cnt), 1);
    step(0, 1, 1, 2);
    chk("chg.ready_low", int'(rdy), 0);
    chk("chg.count2", int'(cnt), 2);
    e34 = '{3, 4, 5, 0, 1, 2, 0};
    for (int i = 0; i < 7; i++) begin
      step(0, 1, 0, 0);
      chk($sformatf("chg.seq%0d", i), int'(cnt), e34[i]);
    end
    chk("chg.ro_end", int'(ro), 1);
    chk("chg.ready_back", int'(rdy), 1);

    // Enable low for 7 cycles at count 2.
    step(1, 0, 0, 0);
    step(0, 1, 1, 7);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("hold.pre", int'(cnt), 2);
    for (int i = 0; i < 7; i++) begin
      step(0, 0, 0, 0);
      chk($sformatf("hold.cnt%0d", i), int'(cnt), 2);
      chk($sformatf("hold.ro%0d", i), int'(ro), 0);
      chk($sformatf("hold.run%0d", i), int'(run), 0);
    end
    step(0, 1, 0, 0);
    chk("hold.resume_cnt", int'(cnt), 2);
    chk("hold.resume_run", int'(run), 1);
    step(0, 1, 0, 0);
    chk("hold.next", int'(cnt), 3);

    // Reset at count 4 with a pending limit.
    step(1, 0, 0, 0);
    step(0, 1, 1, 7);
    step(0, 1, 1, 2);
    chk("rst.pend_rdy", int'(rdy), 0);
    repeat (3) step(0, 1, 0, 0);
    chk("rst.count4", int'(cnt), 4);
    step(1, 1, 1, 5);
    chk("rst.count", int'(cnt), 0);
    chk("rst.ro", int'(ro), 0);
    chk("rst.rc", int'(rc), 0);
    chk("rst.run", int'(run), 0);
    chk("rst.rdy", int'(rdy), 1);
    step(0, 1, 1, 3);
    chk("rst.reload_run", int'(run), 1);
    repeat (3) step(0, 1, 0, 0);
    chk("rst.reload_cnt3", int'(cnt), 3);
    step(0, 1, 0, 0);
    chk("rst.reload_wrap", int'(ro), 1);

    // Randomized traffic against the reference.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 80) == 0, ($urandom % 4) != 0,
           ($urandom % 3) == 0, int'($urandom % 7));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/roll_over_gen.md
ROLL_OVER_GEN -- requirements
Module: roll_over_gen

Interface
REQ-001 Parameter: WIDTH, default 16, counter and limit width in bits.
REQ-002 Parameter: CNT_WIDTH, default 8, width of the rollover event counter.
REQ-003 i_clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 i_reset  input  1  synchronous, active-high reset, sampled on rising i_clk.
REQ-005 i_enable  input  1  high = count advances this cycle; low = hold.
REQ-006 i_limit  input  WIDTH  requested terminal count; period = i_limit+1 cycles.
REQ-007 i_limit_valid  input  1  i_limit offered this cycle.
REQ-008 o_limit_ready  output  1  high = limit transfer accepted when i_limit_valid is also high.
REQ-009 o_roll_over  output  1  one-cycle pulse per period; drives downstream clock-toggle stage.
REQ-010 o_count  output  WIDTH  current count value.
REQ-011 o_roll_cnt  output  CNT_WIDTH  number of rollovers since reset, modulo 2^CNT_WIDTH.
REQ-012 o_running  output  1  high in state S_RUN.

Function
REQ-013 FSM states S_IDLE (no active limit), S_RUN (enabled and counting), S_HOLD (active limit, i_enable low).
REQ-014 S_IDLE -> S_RUN on accepted limit with i_enable high; S_IDLE -> S_HOLD on accepted limit with i_enable low.
REQ-015 S_RUN <-> S_HOLD follows i_enable; the transition takes effect the cycle after i_enable changes.
REQ-016 Handshake: transfer occurs on the rising edge where i_limit_valid and o_limit_ready are both high; i_limit is ignored otherwise.
REQ-017 o_limit_ready is high when the pending-limit register is empty; it is low from transfer until the pending limit is applied.
REQ-018 In S_IDLE, an accepted limit becomes the active limit immediately, with o_count = 0 on the next cycle.
REQ-019 In S_RUN/S_HOLD, an accepted limit is held pending and applied on the rollover edge, so the current period is never truncated.
REQ-020 In S_RUN: if o_count < active limit, o_count increments by 1; if o_count == active limit, o_count wraps to 0.
REQ-021 o_roll_over is registered and high for exactly the one cycle following a wrap edge; it is low in S_IDLE and S_HOLD.
REQ-022 Active limit 0 yields o_roll_over high every cycle while in S_RUN.
REQ-023 o_roll_cnt increments by 1 on each wrap edge and wraps from 2^CNT_WIDTH-1 to 0 without saturating.
REQ-024 In S_HOLD, o_count, the active limit and the pending limit are frozen; a transfer is still accepted if o_limit_ready is high.
REQ-025 If a transfer and a wrap occur on the same edge with the pending register empty, the new limit applies at the next wrap, not at this one.

Reset
REQ-026 i_reset SHALL take priority over all other inputs, including mid-period and mid-handshake.
REQ-027 Reset values: state S_IDLE, o_count 0, o_roll_cnt 0, o_roll_over 0, o_running 0, o_limit_ready 1, active and pending limits 0 and invalid.
REQ-028 A transfer presented during a reset cycle SHALL be discarded.

Structure
REQ-029 Package roll_pkg SHALL hold the state enum type roll_state_t and the default WIDTH and CNT_WIDTH constants.
REQ-030 The pending limit and its valid flag SHALL live in one sub-module, limit_shadow, which owns the ready/valid handshake and the apply strobe.
REQ-031 All outputs SHALL be driven from registers; no combinational path from inputs to o_roll_over.

Verification
REQ-032 Reset; transfer limit 3, enable high -> o_count sequence 0,1,2,3,0; o_roll_over pulses every 4 cycles; o_roll_cnt increments each pulse.
REQ-033 Limit 0, enable high -> o_roll_over high every cycle; o_roll_cnt 255 wraps to 0 with CNT_WIDTH=8.
REQ-034 Running with limit 5, transfer limit 2 at o_count=1 -> o_limit_ready low; period completes at 5; then periods of 3 cycles; ready returns high.
REQ-035 Enable low for 7 cycles at o_count=2 -> o_count frozen at 2, no pulses, o_running low; resume continues at 3.
REQ-036 Assert i_reset at o_count=4 with a transfer pending -> next cycle all outputs at reset values, pending limit discarded, o_limit_ready high.
REQ-037 Transfer coincident with wrap edge (limit 3 -> 1) -> one more period of 4 cycles, then periods of 2 cycles.
